// File: rtl/multiword_add_seq_pkg.sv
// Shared types and constants for the nibble-serial multiword adder.
package multiword_add_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for n nibbles; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder used as the shared nibble slice.
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  always_comb begin
    logic [4:0] carry;
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[4];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// WIDTH-bit adder that reuses one 4-bit slice per cycle, LSB nibble first,
// with valid/ready handshakes on both sides.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("multiword_add_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_sr, b_sr, res_sr;
  logic                    carry_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    sign_a_q, sign_b_q;
  logic [NIBBLE_W-1:0]     slice_sum;
  logic                    slice_co;
  logic [WIDTH+NIBBLE_W-1:0] res_cat;
  logic [WIDTH-1:0]        res_next;
  logic                    accept, last_nibble;

  ripple_carry_adder_4bit u_slice (
    .a     (a_sr[NIBBLE_W-1:0]),
    .b     (b_sr[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_co)
  );

  // New nibble enters at the MSB end; after NIBBLES shifts the result is aligned.
  assign res_cat  = {slice_sum, res_sr};
  assign res_next = res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    last_nibble = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last_nibble = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the operand/result shift registers are plain flops, not a RAM, so clearing them on reset is cheap and keeps state deterministic.
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      ovf      <= 1'b0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      carry_q  <= c_in;
      cnt_q    <= '0;
      sign_a_q <= a[WIDTH-1];
      sign_b_q <= b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr    <= a_sr >> NIBBLE_W;
      b_sr    <= b_sr >> NIBBLE_W;
      res_sr  <= res_next;
      carry_q <= slice_co;
      cnt_q   <= cnt_q + 1'b1;
      // Outputs load only on completion, so a partial result is never visible.
      if (last_nibble) begin
        sum   <= res_next;
        c_out <= slice_co;
        ovf   <= (sign_a_q == sign_b_q) && (res_next[WIDTH-1] != sign_a_q);
      end
    end
  end

endmodule
